i2c_slave_write_word: RTL and testbench

- Parametrised slave transmitter. Shifts a DATA_WIDTH-bit word onto SDA, one bit per SCL low phase.
- After the last data bit it releases SDA for the master ACK/NACK bit, samples that bit, and returns to idle.
- Sits under the slave byte-level FSM. Replaces per-bit sequencing of the single-bit writer.

---
 rtl/i2c_slave_write_word.sv | 142 ++++++++++++++
 tb/tb_i2c_slave_write_word.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_write_word.sv
// i2c_slave_write_word: shifts a DATA_WIDTH-bit word onto SDA, then samples the master ACK/NACK bit.
// Define I2C_SLAVE_WRITE_WORD_SDA_HOLD_EN to defer fall-triggered SDA updates by HOLD_CYCLES clocks.
module i2c_slave_write_word #(
  parameter int DATA_WIDTH  = 8,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  scl,
  input  logic                  sda_in,
  output logic                  sda,
  output logic                  busy,
  output logic                  finish,
  output logic                  nack
);
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, ACK} state_t;
  state_t                state_q, state_d;
  logic                  scl_last_q;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, nxt;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  sda_q, sda_d, busy_q, busy_d, finish_q, finish_d;
  logic                  nack_q, nack_d, ack_bit_q, ack_bit_d;
  logic                  fall, rise, last, upd;
`ifdef I2C_SLAVE_WRITE_WORD_SDA_HOLD_EN
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  logic          pend_q, pend_d, pend_val_q, pend_val_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
`else
  logic          hold_unused;
  assign hold_unused = |HOLD_CYCLES;
`endif
  assign fall   = scl_last_q & ~scl;
  assign rise   = ~scl_last_q & scl;
  assign sda    = sda_q;
  assign busy   = busy_q;
  assign finish = finish_q;
  assign nack   = nack_q;
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    sda_d     = sda_q;
    busy_d    = busy_q;
    finish_d  = 1'b0;
    nack_d    = nack_q;
    ack_bit_d = ack_bit_q;
    nxt       = MSB_FIRST ? shift_q << 1 : shift_q >> 1;
    last      = bit_cnt_q == CW'(DATA_WIDTH - 1);
    upd       = last ? 1'b1 : (MSB_FIRST ? nxt[DATA_WIDTH-1] : nxt[0]);
`ifdef I2C_SLAVE_WRITE_WORD_SDA_HOLD_EN
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    hold_cnt_d = hold_cnt_q;
    // A rising SCL forces out any pending update so the bit is stable while SCL is high
    if (pend_q) begin
      if (rise || hold_cnt_q == '0) begin
        sda_d  = pend_val_q;
        pend_d = 1'b0;
      end else begin
        hold_cnt_d = hold_cnt_q - HW'(1);
      end
    end
`endif
    case (state_q)
      IDLE: begin
        if (enable && !scl) begin
          shift_d   = data;
          bit_cnt_d = '0;
          sda_d     = MSB_FIRST ? data[DATA_WIDTH-1] : data[0];
          busy_d    = 1'b1;
          state_d   = SHIFT;
`ifdef I2C_SLAVE_WRITE_WORD_SDA_HOLD_EN
          pend_d    = 1'b0;
`endif
        end
      end
      SHIFT: begin
        if (fall) begin
          state_d = last ? ACK : SHIFT;
          if (!last) begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            shift_d   = nxt;
          end
`ifdef I2C_SLAVE_WRITE_WORD_SDA_HOLD_EN
          pend_d     = 1'b1;
          pend_val_d = upd;
          hold_cnt_d = HW'(HOLD_CYCLES - 1);
`else
          sda_d      = upd;
`endif
        end
      end
      ACK: begin
        if (rise) ack_bit_d = sda_in;
        if (fall) begin
          nack_d   = ack_bit_q;
          finish_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      scl_last_q <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      sda_q      <= 1'b1;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
      nack_q     <= 1'b0;
      ack_bit_q  <= 1'b0;
`ifdef I2C_SLAVE_WRITE_WORD_SDA_HOLD_EN
      pend_q     <= 1'b0;
      pend_val_q <= 1'b1;
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      scl_last_q <= scl;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      sda_q      <= sda_d;
      busy_q     <= busy_d;
      finish_q   <= finish_d;
      nack_q     <= nack_d;
      ack_bit_q  <= ack_bit_d;
`ifdef I2C_SLAVE_WRITE_WORD_SDA_HOLD_EN
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_i2c_slave_write_word.sv
// tb_i2c_slave_write_word: randomized word transfers on MSB-first and LSB-first instances against a bit-order model.
module tb_i2c_slave_write_word;
`ifdef I2C_SLAVE_WRITE_WORD_SDA_HOLD_EN
  localparam int LO_MIN = 4;
  localparam int LO_MAX = 6;
`else
  localparam int LO_MIN = 2;
  localparam int LO_MAX = 4;
`endif
  logic clock = 1'b0;
  logic reset_n, en, scl, sda_in, sel;
  logic [7:0] data;
  logic sda_m, busy_m, fin_m, nack_m, sda_l, busy_l, fin_l, nack_l;
  logic o_sda, o_busy, o_fin, o_nack;
  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  i2c_slave_write_word #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .HOLD_CYCLES(4)) u_msb (
    .clock(clock), .reset_n(reset_n), .enable(en & ~sel), .data(data), .scl(scl),
    .sda_in(sda_in), .sda(sda_m), .busy(busy_m), .finish(fin_m), .nack(nack_m));
  i2c_slave_write_word #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .HOLD_CYCLES(4)) u_lsb (
    .clock(clock), .reset_n(reset_n), .enable(en & sel), .data(data), .scl(scl),
    .sda_in(sda_in), .sda(sda_l), .busy(busy_l), .finish(fin_l), .nack(nack_l));

  assign o_sda  = sel ? sda_l  : sda_m;
  assign o_busy = sel ? busy_l : busy_m;
  assign o_fin  = sel ? fin_l  : fin_m;
  assign o_nack = sel ? nack_l : nack_m;

  // bit i of the serial stream for the currently selected bit order
  function automatic logic exp_bit(input logic [7:0] w, input int i);
    return sel ? w[i] : w[7-i];
  endfunction

  task automatic start_word(input logic [7:0] w);
    en = 1'b1; data = w;
    @(negedge clock);
    en = 1'b0;
    checks += 3;
    if (o_busy !== 1'b1) $display("FAIL start_busy w=%h got %b want 1", w, o_busy); else passes++;
    if (o_sda !== exp_bit(w, 0)) $display("FAIL start_sda w=%h got %b want %b", w, o_sda, exp_bit(w, 0)); else passes++;
    if (o_fin !== 1'b0) $display("FAIL start_finish w=%h got %b want 0", w, o_fin); else passes++;
  endtask

  task automatic body(input logic [7:0] w, input logic ack, input bit poke, input int stop_at);
    int lo, hi;
    logic exp;
    for (int i = 0; i < 9; i++) begin
      lo = $urandom_range(LO_MAX, LO_MIN);
      hi = $urandom_range(3, 1);
      if (poke && i == 3) begin
        en = 1'b1; data = 8'hFF;
        @(negedge clock);
        en = 1'b0; lo--;
      end
      repeat (lo) @(negedge clock);
      exp = i < 8 ? exp_bit(w, i) : 1'b1;
      checks++;
      if (o_sda !== exp) $display("FAIL sda_low w=%h bit=%0d got %b want %b", w, i, o_sda, exp); else passes++;
      if (i == 8) sda_in = ack;
      scl = 1'b1;
      repeat (hi) @(negedge clock);
      checks += 2;
      if (o_sda !== exp) $display("FAIL sda_high w=%h bit=%0d got %b want %b", w, i, o_sda, exp); else passes++;
      if (o_busy !== 1'b1) $display("FAIL busy_mid w=%h bit=%0d got %b want 1", w, i, o_busy); else passes++;
      scl = 1'b0;
      sda_in = 1'($urandom);
      @(negedge clock);
      if (i == stop_at) return;
    end
    checks += 3;
    if (o_fin !== 1'b1) $display("FAIL finish w=%h got %b want 1", w, o_fin); else passes++;
    if (o_busy !== 1'b0) $display("FAIL busy_end w=%h got %b want 0", w, o_busy); else passes++;
    if (o_nack !== ack) $display("FAIL nack w=%h got %b want %b", w, o_nack, ack); else passes++;
  endtask

  task automatic finish_drop(input string tag);
    @(negedge clock);
    checks += 2;
    if (o_fin !== 1'b0) $display("FAIL %s_finish_len got %b want 0", tag, o_fin); else passes++;
    if (o_busy !== 1'b0) $display("FAIL %s_idle_busy got %b want 0", tag, o_busy); else passes++;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; en = 1'b0; scl = 1'b1; sda_in = 1'b1; sel = 1'b0; data = '0;
    repeat (2) @(negedge clock);
    checks += 4;
    if ({sda_m, sda_l} !== 2'b11) $display("FAIL reset_sda got %b want 11", {sda_m, sda_l}); else passes++;
    if ({busy_m, busy_l} !== 2'b00) $display("FAIL reset_busy got %b want 00", {busy_m, busy_l}); else passes++;
    if ({fin_m, fin_l} !== 2'b00) $display("FAIL reset_finish got %b want 00", {fin_m, fin_l}); else passes++;
    if ({nack_m, nack_l} !== 2'b00) $display("FAIL reset_nack got %b want 00", {nack_m, nack_l}); else passes++;
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_ignored;
    scl = 1'b1; en = 1'b1; data = 8'h5A;
    repeat (2) @(negedge clock);
    en = 1'b0;
    checks += 2;
    if (o_busy !== 1'b0) $display("FAIL ign_scl_high_busy got %b want 0", o_busy); else passes++;
    if (o_sda !== 1'b1) $display("FAIL ign_scl_high_sda got %b want 1", o_sda); else passes++;
    scl = 1'b0;
    @(negedge clock);
    start_word(8'h00);
    body(8'h00, 1'b0, 1'b1, -1);
    finish_drop("ign");
  endtask

  task automatic test_directed;
    sel = 1'b0;
    start_word(8'hA5);
    body(8'hA5, 1'b0, 1'b0, -1);
    finish_drop("a5");
    sel = 1'b1;
    start_word(8'h01);
    body(8'h01, 1'b1, 1'b0, -1);
    finish_drop("lsb01");
  endtask

  task automatic test_back_to_back;
    logic [7:0] w;
    sel = 1'b0;
    w = 8'($urandom);
    start_word(w);
    body(w, 1'b0, 1'b0, -1);
    start_word(8'h3C);
    body(8'h3C, 1'b1, 1'b0, -1);
    finish_drop("b2b");
  endtask

  task automatic test_reset_mid;
    sel = 1'b0;
    start_word(8'h0F);
    body(8'h0F, 1'b0, 1'b0, 2);
    repeat (LO_MIN) @(negedge clock);
    checks++;
    if (o_sda !== 1'b0) $display("FAIL rmid_pre_sda got %b want 0", o_sda); else passes++;
    #3 reset_n = 1'b0;
    #1;
    checks += 2;
    if (o_sda !== 1'b1) $display("FAIL rmid_async_sda got %b want 1", o_sda); else passes++;
    if (o_busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", o_busy); else passes++;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (k == 2) reset_n = 1'b1;
      scl = k[0];
      checks++;
      if (o_fin !== 1'b0) $display("FAIL rmid_finish k=%0d got %b want 0", k, o_fin); else passes++;
    end
    scl = 1'b0;
    @(negedge clock);
    start_word(8'h80);
    body(8'h80, 1'b0, 1'b0, -1);
    finish_drop("rmid");
  endtask

  task automatic test_random;
    logic [7:0] w;
    logic ack;
    for (int n = 0; n < 16; n++) begin
      sel = 1'($urandom);
      w = 8'($urandom);
      ack = 1'($urandom);
      start_word(w);
      body(w, ack, 1'b0, -1);
      if (n[1:0] == 2'b11) finish_drop("rnd");
    end
    finish_drop("rnd_end");
  endtask

`ifdef I2C_SLAVE_WRITE_WORD_SDA_HOLD_EN
  task automatic test_hold;
    logic old_v, new_v;
    sel = 1'b0; sda_in = 1'b0;
    start_word(8'h55);
    for (int i = 0; i < 8; i++) begin
      old_v = exp_bit(8'h55, i);
      new_v = i < 7 ? exp_bit(8'h55, i + 1) : 1'b1;
      scl = 1'b1;
      repeat (2) @(negedge clock);
      scl = 1'b0;
      for (int k = 0; k < (i[0] ? 3 : 4); k++) begin
        @(negedge clock);
        checks++;
        if (o_sda !== old_v) $display("FAIL hold_old bit=%0d k=%0d got %b want %b", i, k, o_sda, old_v); else passes++;
      end
      if (i[0]) scl = 1'b1;
      @(negedge clock);
      checks++;
      if (o_sda !== new_v) $display("FAIL hold_new bit=%0d got %b want %b", i, o_sda, new_v); else passes++;
    end
    scl = 1'b1;
    repeat (2) @(negedge clock);
    scl = 1'b0;
    @(negedge clock);
    checks += 2;
    if (o_fin !== 1'b1) $display("FAIL hold_finish got %b want 1", o_fin); else passes++;
    if (o_nack !== 1'b0) $display("FAIL hold_nack got %b want 0", o_nack); else passes++;
    finish_drop("hold");
  endtask
`endif

  initial begin
    test_reset;
    test_ignored;
    test_directed;
    test_back_to_back;
    test_reset_mid;
    test_random;
`ifdef I2C_SLAVE_WRITE_WORD_SDA_HOLD_EN
    test_hold;
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
